// File: rtl/spi_define.sv
// rtl/spi_define.sv - Frame-width encodings, FSM state type and helpers shared by the SPI cores.
package spi_define;

  localparam logic [1:0] DTB_8  = 2'b00;
  localparam logic [1:0] DTB_16 = 2'b01;
  localparam logic [1:0] DTB_24 = 2'b10;
  localparam logic [1:0] DTB_32 = 2'b11;

  typedef logic [1:0] spi_state_t;
  localparam spi_state_t ST_IDLE  = 2'd0;
  localparam spi_state_t ST_LOAD  = 2'd1;
  localparam spi_state_t ST_SHIFT = 2'd2;

  function automatic logic [5:0] dtb_bits(input logic [1:0] dtb);
    case (dtb)
      DTB_8:   return 6'd8;
      DTB_16:  return 6'd16;
      DTB_24:  return 6'd24;
      DTB_32:  return 6'd32;
      default: return 6'd8;
    endcase
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - SPI input synchronizers, optional majority filter (SPI_SLAVE_FILTER_EN), sck edge detect.
module spi_slave_sync
  import spi_define::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sck,
  input  logic i_nss,
  input  logic i_mosi,
  output logic o_nss,
  output logic o_mosi,
  output logic o_sck_rise,
  output logic o_sck_fall
);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_nss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_prev;
  logic                   w_sck;
  logic                   w_nss;
  logic                   w_mosi;
  logic                   w_sck_f;
  logic                   w_nss_f;
  logic                   w_mosi_f;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sck_sync  <= '0;
      r_nss_sync  <= '1;
      r_mosi_sync <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_nss_sync  <= {r_nss_sync[SYNC_STAGES-2:0], i_nss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
    end
  end

  assign w_sck  = r_sck_sync[SYNC_STAGES-1];
  assign w_nss  = r_nss_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

`ifdef SPI_SLAVE_FILTER_EN
  logic [1:0] r_sck_hist;
  logic [1:0] r_nss_hist;
  logic       r_mosi_dly;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sck_hist <= 2'b00;
      r_nss_hist <= 2'b11;
      r_mosi_dly <= 1'b0;
    end else begin
      r_sck_hist <= {r_sck_hist[0], w_sck};
      r_nss_hist <= {r_nss_hist[0], w_nss};
      r_mosi_dly <= w_mosi;
    end
  end

  // mosi is delayed by one cycle so it stays aligned with the filtered sck edge
  assign w_sck_f  = maj3(w_sck, r_sck_hist[0], r_sck_hist[1]);
  assign w_nss_f  = maj3(w_nss, r_nss_hist[0], r_nss_hist[1]);
  assign w_mosi_f = r_mosi_dly;
`else
  assign w_sck_f  = w_sck;
  assign w_nss_f  = w_nss;
  assign w_mosi_f = w_mosi;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sck_prev <= 1'b0;
    end else begin
      r_sck_prev <= w_sck_f;
    end
  end

  assign o_nss      = w_nss_f;
  assign o_mosi     = w_mosi_f;
  assign o_sck_rise = w_sck_f & ~r_sck_prev;
  assign o_sck_fall = ~w_sck_f & r_sck_prev;

endmodule

// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - SPI slave: tx holding register, IDLE/LOAD/SHIFT framing, rx handshake.
module spi_slave_core
  import spi_define::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  lsb_i,
  input  logic [1:0]            dtb_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  busy_o,
  output logic                  ovr_o,
  output logic                  udr_o,
  input  logic                  spi_sck_i,
  input  logic                  spi_nss_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_en_o
);

  localparam int IW = $clog2(DATA_WIDTH);

  logic                  w_nss, w_mosi, w_sck_rise, w_sck_fall;
  logic                  w_lead, w_trail, w_abort, w_nss_fall;
  logic                  w_sample, w_shift, w_last;
  logic [5:0]            w_ld_bits, w_rx_idx6;
  logic [DATA_WIDTH-1:0] w_ld_data, w_rx_next;

  spi_state_t            r_state;
  logic                  r_nss_prev;
  logic [DATA_WIDTH-1:0] r_hold, r_tx_sr, r_rx_sr, r_rx_data;
  logic                  r_hold_full, r_rx_valid, r_ovr, r_udr, r_udr_pend, r_miso;
  logic [5:0]            r_cnt, r_nbits;
  logic                  r_cpol, r_cpha, r_lsb;

  function automatic logic f_head(input logic [DATA_WIDTH-1:0] d, input logic lsb, input logic [5:0] n);
    logic [5:0] idx;
    idx = n - 6'd1;
    return lsb ? d[0] : d[idx[IW-1:0]];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_adv(input logic [DATA_WIDTH-1:0] d, input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk      (clk_i),
    .i_rst_n    (rst_n_i),
    .i_sck      (spi_sck_i),
    .i_nss      (spi_nss_i),
    .i_mosi     (spi_mosi_i),
    .o_nss      (w_nss),
    .o_mosi     (w_mosi),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall)
  );

  assign w_lead     = r_cpol ? w_sck_fall : w_sck_rise;
  assign w_trail    = r_cpol ? w_sck_rise : w_sck_fall;
  assign w_abort    = w_nss | ~en_i;
  assign w_nss_fall = r_nss_prev & ~w_nss;
  assign w_sample   = (r_state == ST_SHIFT) & (r_cpha ? w_trail : w_lead);
  // in mode cpha=0 the trailing edge left over from the previous frame must not shift
  assign w_shift    = (r_state == ST_SHIFT) & (r_cpha ? w_lead : w_trail) & (r_cpha | (r_cnt != 6'd0));
  assign w_last     = w_sample & ((r_cnt + 6'd1) == r_nbits);
  assign w_ld_bits  = dtb_bits(dtb_i);
  assign w_ld_data  = r_hold_full ? r_hold : '0;
  assign w_rx_idx6  = r_lsb ? r_cnt : (r_nbits - 6'd1 - r_cnt);

  always_comb begin
    w_rx_next = r_rx_sr;
    w_rx_next[w_rx_idx6[IW-1:0]] = w_mosi;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_nss_prev  <= 1'b1;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx_sr     <= '0;
      r_rx_sr     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_ovr       <= 1'b0;
      r_udr       <= 1'b0;
      r_udr_pend  <= 1'b0;
      r_miso      <= 1'b0;
      r_cnt       <= '0;
      r_nbits     <= 6'd8;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_lsb       <= 1'b0;
    end else begin
      r_nss_prev <= w_nss;
      r_ovr      <= 1'b0;
      r_udr      <= 1'b0;
      if (tx_valid_i && !r_hold_full) begin
        r_hold      <= tx_data_i;
        r_hold_full <= 1'b1;
      end
      if (r_rx_valid && rx_ready_i) r_rx_valid <= 1'b0;
      if (w_abort) begin
        r_state    <= ST_IDLE;
        r_tx_sr    <= '0;
        r_rx_sr    <= '0;
        r_cnt      <= '0;
        r_miso     <= 1'b0;
        r_udr_pend <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: if (w_nss_fall) r_state <= ST_LOAD;
          ST_LOAD: begin
            r_state <= ST_SHIFT;
            r_cpol  <= cpol_i;
            r_cpha  <= cpha_i;
            r_lsb   <= lsb_i;
            r_nbits <= w_ld_bits;
            r_cnt   <= '0;
            r_rx_sr <= '0;
            if (r_hold_full) r_hold_full <= 1'b0;
            // underrun is reported only once the zero word actually starts shifting
            r_udr_pend <= ~r_hold_full;
            if (cpha_i) begin
              r_miso  <= 1'b0;
              r_tx_sr <= w_ld_data;
            end else begin
              r_miso  <= f_head(w_ld_data, lsb_i, w_ld_bits);
              r_tx_sr <= f_adv(w_ld_data, lsb_i);
            end
          end
          ST_SHIFT: begin
            if (w_shift) begin
              r_miso  <= f_head(r_tx_sr, r_lsb, r_nbits);
              r_tx_sr <= f_adv(r_tx_sr, r_lsb);
            end
            if (w_sample) begin
              r_cnt   <= r_cnt + 6'd1;
              r_rx_sr <= w_rx_next;
              if (r_udr_pend) begin
                r_udr      <= 1'b1;
                r_udr_pend <= 1'b0;
              end
              if (w_last) begin
                r_state <= ST_LOAD;
                if (r_rx_valid && !rx_ready_i) begin
                  r_ovr <= 1'b1;
                end else begin
                  r_rx_data  <= w_rx_next;
                  r_rx_valid <= 1'b1;
                end
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx_ready_o    = ~r_hold_full;
  assign rx_valid_o    = r_rx_valid;
  assign rx_data_o     = r_rx_data;
  assign busy_o        = (r_state != ST_IDLE);
  assign ovr_o         = r_ovr;
  assign udr_o         = r_udr;
  assign spi_miso_en_o = ~w_nss & en_i;
  assign spi_miso_o    = spi_miso_en_o & r_miso;

endmodule
